// File: rtl/eth_pkt_fifo_if.sv
// Ingress/egress beat handshake bundle for eth_pkt_fifo.
// The slave modport is the FIFO side. The master modport is the producer/consumer side.
interface eth_pkt_fifo_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_vld;
  logic              out_rdy;

  modport slave (
    input  in_data, in_sop, in_eop, in_vld, out_rdy,
    output in_rdy, out_data, out_sop, out_eop, out_vld
  );

  modport master (
    output in_data, in_sop, in_eop, in_vld, out_rdy,
    input  in_rdy, out_data, out_sop, out_eop, out_vld
  );
endinterface

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward Ethernet frame buffer: frames become visible only once committed; bad frames are dropped whole.
// Optional drop counter output enabled by defining ETH_PKT_FIFO_DROP_CNT_EN.
module eth_pkt_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetN,
  eth_pkt_fifo_if.slave    bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] fill_lvl,
  output logic             drop_pulse
`ifdef ETH_PKT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DISCARD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wr_com;
  logic [CNT_W-1:0]  wr_spec;
  logic [CNT_W-1:0]  rd_ptr;
  logic              in_rdy_q;
  logic [DATA_W+1:0] mem [DEPTH];

  logic              accept;
  logic              start;
  logic              writing;
  logic              overflow;
  logic              do_write;
  logic              do_commit;
  logic              do_drop;
  logic [CNT_W-1:0]  wr_base;
  logic [DATA_W+1:0] rd_word;
  logic              rd_fire;
  logic              rd_last;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    accept   = bus.in_vld && in_rdy_q;
    start    = accept && bus.in_sop;
    // A new frame always starts at the committed pointer, discarding any partial frame.
    wr_base  = start ? wr_com : wr_spec;
    overflow = ((wr_base - rd_ptr) == FULL_LVL);
    writing  = accept && (start || (state == S_WRITE));
    do_write = writing && !overflow;
    do_commit = do_write && bus.in_eop;
    do_drop  = (writing && overflow) || (start && (state == S_WRITE));
  end

  always_comb begin
    rd_word      = mem[rd_ptr[AW-1:0]];
    bus.out_vld  = (frame_cnt != '0);
    bus.out_data = '0;
    bus.out_sop  = 1'b0;
    bus.out_eop  = 1'b0;
    if (bus.out_vld) begin
      bus.out_data = rd_word[DATA_W-1:0];
      bus.out_sop  = rd_word[DATA_W];
      bus.out_eop  = rd_word[DATA_W+1];
    end
    rd_fire = bus.out_vld && bus.out_rdy;
    rd_last = rd_fire && rd_word[DATA_W+1];
  end

  assign bus.in_rdy = in_rdy_q;
  assign fill_lvl   = wr_com - rd_ptr;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= S_IDLE;
      wr_com     <= '0;
      wr_spec    <= '0;
      rd_ptr     <= '0;
      frame_cnt  <= '0;
      in_rdy_q   <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      in_rdy_q   <= 1'b1;
      drop_pulse <= do_drop;

      if (do_write) begin
        wr_spec <= wr_base + 1'b1;
        if (do_commit) begin
          wr_com <= wr_base + 1'b1;
          state  <= S_IDLE;
        end else begin
          state  <= S_WRITE;
        end
      end else if (writing) begin
        // Overflowing beat: throw away the whole frame written so far.
        wr_spec <= wr_com;
        state   <= bus.in_eop ? S_IDLE : S_DISCARD;
      end else if (accept && bus.in_eop && (state == S_DISCARD)) begin
        state <= S_IDLE;
      end

      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      frame_cnt <= frame_cnt + CNT_W'(do_commit) - CNT_W'(rd_last);
    end
  end

  // NOTE: the storage array has no reset; pointers and frame_cnt alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_base[AW-1:0]] <= {bus.in_eop, bus.in_sop, bus.in_data};
    end
  end

`ifdef ETH_PKT_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drop_cnt <= '0;
    end else if (drop_pulse && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
